// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART APB streamer:
//     apb_state_e     - APB master FSM state encoding
//     UART_TX_OFFSET  - UART transmit-data register offset
//     UART_RX_OFFSET  - UART receive-data register offset
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } apb_state_e;

    localparam logic [4:0] UART_TX_OFFSET = 5'h00;
    localparam logic [4:0] UART_RX_OFFSET = 5'h04;

endpackage

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
//   Byte-wide synchronous FIFO holding bytes read from the UART.
//   Ports:
//     clk, rst_n         - clock, asynchronous active-low reset
//     push, wdata        - write strobe and byte
//     pop                - read strobe (head advances)
//     rdata              - head byte, forced to 0 while empty
//     full, empty, count - occupancy status (count is log2(DEPTH)+1 bits)
//   DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module uart_byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = empty ? 8'h00 : r_mem[r_rd_ptr];

    // Guarded strobes keep the state consistent even if a caller misbehaves.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_apb_streamer.sv
// -----------------------------------------------------------------------------
// uart_apb_streamer
//   APB master that moves bytes between valid/ready streams and a UART:
//   writes tx bytes to TX_ADDR when TXRDY, reads RX_ADDR into a FIFO when
//   RXRDY. Reads win over writes. Each transfer is IDLE->SETUP->ACCESS->HOLD;
//   HOLD is a dead cycle so stale TXRDY/RXRDY from the just-finished transfer
//   are not acted on.
//   Ports:
//     PCLK, PRESETN                        - clock, async active-low reset
//     PADDR/PSEL/PENABLE/PWRITE/PWDATA     - APB request (registered)
//     PRDATA/PREADY/PSLVERR                - APB response
//     TXRDY/RXRDY/OVERFLOW                 - UART status
//     tx_valid/tx_ready/tx_data            - byte stream into the UART
//     rx_valid/rx_ready/rx_data            - byte stream out of the UART
//     err_cnt                              - saturating error count
//   Optional feature: define UART_STREAMER_ERR_CNT_EN to build the error
//   counter; otherwise err_cnt is tied to 0.
// -----------------------------------------------------------------------------
module uart_apb_streamer
    import uart_pkg::*;
#(
    parameter logic [4:0] TX_ADDR  = UART_TX_OFFSET,
    parameter logic [4:0] RX_ADDR  = UART_RX_OFFSET,
    parameter int         RX_DEPTH = 4
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       TXRDY,
    input  logic       RXRDY,
    input  logic       OVERFLOW,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic [7:0] err_cnt
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    apb_state_e r_state;
    logic [4:0] r_paddr;
    logic       r_psel;
    logic       r_penable;
    logic       r_pwrite;
    logic [7:0] r_pwdata;

    logic          w_rd_go;
    logic          w_wr_go;
    logic          w_done;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    assign PADDR   = r_paddr;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PWDATA  = r_pwdata;

    // Arbitration in IDLE: a read needs FIFO room, so a push can never be lost.
    assign w_rd_go = (r_state == IDLE) && RXRDY && !w_fifo_full;
    assign w_wr_go = (r_state == IDLE) && !w_rd_go && TXRDY && tx_valid;

    // The handshake is combinational so tx_data is captured in the same cycle;
    // qualified by reset because the FSM sits in IDLE while reset is held.
    assign tx_ready = w_wr_go && PRESETN;

    assign w_done = (r_state == ACCESS) && PREADY;
    assign w_push = w_done && !r_pwrite;     // PSLVERR does not suppress the push
    assign w_pop  = rx_valid && rx_ready;
    assign rx_valid = !w_fifo_empty;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state   <= IDLE;
            r_paddr   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rd_go) begin
                        r_state  <= SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= RX_ADDR;
                        r_pwrite <= 1'b0;
                    end else if (w_wr_go) begin
                        r_state  <= SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= TX_ADDR;
                        r_pwrite <= 1'b1;
                        r_pwdata <= tx_data;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_state   <= HOLD;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                HOLD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    uart_byte_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (PRDATA),
        .rdata (rx_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    logic w_unused_cnt;
    assign w_unused_cnt = ^w_fifo_count;

`ifdef UART_STREAMER_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic [1:0] w_err_inc;
    logic [8:0] w_err_sum;

    // A slave error and an overflow in the same cycle count as two events.
    assign w_err_inc = {1'b0, (w_done && PSLVERR)} + {1'b0, OVERFLOW};
    assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) r_err_cnt <= '0;
        else          r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = PSLVERR ^ OVERFLOW;
    assign err_cnt      = 8'h00;
`endif

endmodule

// File: tb/tb_uart_apb_streamer.sv
module tb_uart_apb_streamer;

    logic       PCLK = 1'b0;
    logic       PRESETN;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR, TXRDY, RXRDY, OVERFLOW;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0] tx_data, rx_data, err_cnt;

    always #5 PCLK = ~PCLK;

    uart_apb_streamer dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TXRDY(TXRDY), .RXRDY(RXRDY), .OVERFLOW(OVERFLOW),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .err_cnt(err_cnt)
    );

`ifdef UART_STREAMER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int exp_err = 0;
    logic [7:0] rq[$];   // expected rx bytes
    logic [7:0] wq[$];   // expected APB write data

    function automatic int err_add(input int cur, input int inc);
        if (!ERR_EN) return 0;
        return (cur + inc > 255) ? 255 : cur + inc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // One-cycle pop, head compared against the scoreboard.
    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (rq.size() > 0) ? rq.pop_front() : 8'hxx;
        rx_ready = 1'b1;
        settle();
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, e);
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int k;
        int done;
        bit seen;

        PRESETN = 1'b0; PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
        TXRDY = 1'b0; RXRDY = 1'b0; OVERFLOW = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;

        // ---- reset state, with a write request pending ----
        #12;
        tx_valid = 1'b1; TXRDY = 1'b1;
        settle();
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        tx_valid = 1'b0; TXRDY = 1'b0;
        tick();
        PRESETN = 1'b1;
        tick();

        // ---- single write, PREADY=1 ----
        tx_valid = 1'b1; tx_data = 8'hA5; TXRDY = 1'b1; PREADY = 1'b1;
        settle();
        check("wr_tx_ready_c0", tx_ready, 1);
        wq.push_back(8'hA5);
        tick();
        tx_valid = 1'b0; TXRDY = 1'b0;
        settle();
        check("wr_tx_ready_c1", tx_ready, 0);
        check("wr_psel_c1", PSEL, 1);
        check("wr_penable_c1", PENABLE, 0);
        check("wr_paddr_c1", PADDR, 5'h00);
        check("wr_pwrite_c1", PWRITE, 1);
        check("wr_pwdata_c1", PWDATA, wq.pop_front());
        tick();
        check("wr_psel_c2", PSEL, 1);
        check("wr_penable_c2", PENABLE, 1);
        tick();
        check("wr_psel_c3", PSEL, 0);
        check("wr_penable_c3", PENABLE, 0);
        tick();
        check("wr_pwdata_hold", PWDATA, 8'hA5);
        check("wr_pwrite_hold", PWRITE, 1);

        // ---- read with 3 wait cycles ----
        RXRDY = 1'b1; PRDATA = 8'h3C; PREADY = 1'b0;
        rq.push_back(8'h3C);
        tick();
        check("rd_psel_setup", PSEL, 1);
        check("rd_penable_setup", PENABLE, 0);
        check("rd_paddr", PADDR, 5'h04);
        check("rd_pwrite", PWRITE, 0);
        RXRDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_penable_wait", PENABLE, 1);
            check("rd_rx_valid_wait", rx_valid, 0);
        end
        tick();
        PREADY = 1'b1;
        check("rd_penable_last", PENABLE, 1);
        tick();
        check("rd_psel_hold", PSEL, 0);
        pop_check("rd_pop");
        settle();
        check("rd_empty_after_pop", rx_valid, 0);

        // ---- read/write collision: read first ----
        RXRDY = 1'b1; TXRDY = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; PRDATA = 8'hC3;
        rq.push_back(8'hC3);
        settle();
        check("pri_tx_ready_c0", tx_ready, 0);
        tick();
        check("pri_paddr_rd", PADDR, 5'h04);
        check("pri_pwrite_rd", PWRITE, 0);
        RXRDY = 1'b0;
        settle();
        check("pri_tx_ready_setup", tx_ready, 0);
        tick();
        tick();
        settle();
        check("pri_tx_ready_hold", tx_ready, 0);
        tick();
        settle();
        check("pri_tx_ready_idle", tx_ready, 1);
        wq.push_back(8'h5A);
        tick();
        tx_valid = 1'b0; TXRDY = 1'b0;
        check("pri_paddr_wr", PADDR, 5'h00);
        check("pri_pwrite_wr", PWRITE, 1);
        check("pri_pwdata_wr", PWDATA, wq.pop_front());
        tick(); tick(); tick();
        pop_check("pri_pop");

        // ---- FIFO full back-pressure ----
        RXRDY = 1'b1; PREADY = 1'b1; k = 0;
        for (int c = 0; c < 40; c++) begin
            if (PSEL && !PENABLE) begin
                PRDATA = 8'(8'h10 + k);
                rq.push_back(PRDATA);
                k++;
            end
            tick();
        end
        check("full_read_count", k, 4);
        check("full_rx_valid", rx_valid, 1);
        check("full_psel_idle", PSEL, 0);
        pop_check("full_pop0");
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (PSEL) begin seen = 1'b1; break; end
        end
        check("full_read_resume", seen, 1);
        PRDATA = 8'h14;
        rq.push_back(8'h14);
        RXRDY = 1'b0;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 4; i++) pop_check("full_drain");
        settle();
        check("full_drained", rx_valid, 0);

        // ---- reset in the middle of a read ----
        RXRDY = 1'b1; PREADY = 1'b0; PRDATA = 8'hEE;
        tick();
        tick();
        check("rstacc_penable_pre", PENABLE, 1);
        PRESETN = 1'b0;
        settle();
        check("rstacc_psel", PSEL, 0);
        check("rstacc_penable", PENABLE, 0);
        check("rstacc_rx_valid", rx_valid, 0);
        RXRDY = 1'b0; PREADY = 1'b1;
        tick();
        PRESETN = 1'b1;
        tick(); tick(); tick();
        check("rstacc_no_retry", PSEL, 0);
        check("rstacc_no_push", rx_valid, 0);

        // ---- error counter: slave error + overflow together, then overflow ----
        RXRDY = 1'b1; PRDATA = 8'h66; PREADY = 1'b1;
        rq.push_back(8'h66);
        tick();
        RXRDY = 1'b0;
        tick();
        PSLVERR = 1'b1; OVERFLOW = 1'b1;
        tick();
        exp_err = err_add(exp_err, 2);
        PSLVERR = 1'b0; OVERFLOW = 1'b0;
        check("err_both", err_cnt, exp_err);
        pop_check("err_pop");
        OVERFLOW = 1'b1;
        tick();
        OVERFLOW = 1'b0;
        exp_err = err_add(exp_err, 1);
        check("err_ovf", err_cnt, exp_err);

        // ---- 300 slave-error completions, saturation ----
        RXRDY = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1; rx_ready = 1'b1; PRDATA = 8'h77;
        done = 0;
        for (int c = 0; c < 2000 && done < 300; c++) begin
            if (PSEL && PENABLE) begin
                if (done % 50 == 0) check("err_running", err_cnt, exp_err);
                done++;
                exp_err = err_add(exp_err, 1);
                if (done == 300) RXRDY = 1'b0;
            end
            tick();
        end
        PSLVERR = 1'b0;
        tick(); tick();
        rx_ready = 1'b0;
        check("err_completions", done, 300);
        check("err_saturated", err_cnt, exp_err);
        check("err_drained", rx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
